// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one multi-byte UART sender among REQ_NUM requesters.
// Optional macro TX_ARB_PRIO_EN: requester 0 wins in IDLE without moving the rr pointer.
module uart_tx_arbiter #(
  parameter int unsigned REQ_NUM       = 4,
  parameter int unsigned BYTE_NUM      = 4,
  parameter int unsigned START_TIMEOUT = 16,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [REQ_NUM-1:0]            req_i,
  input  logic [REQ_NUM*8*BYTE_NUM-1:0] req_data_i,
  output logic [REQ_NUM-1:0]            grant_o,
  output logic [REQ_NUM-1:0]            done_o,
  output logic [REQ_NUM-1:0]            err_o,
  output logic                          send_en_o,
  output logic [8*BYTE_NUM-1:0]         nbytes_data_o,
  input  logic                          tx_busy_i,
  output logic                          arb_busy_o
);

  localparam int unsigned FW   = 8 * BYTE_NUM;
  localparam int unsigned PW   = $clog2(REQ_NUM);
  localparam int unsigned CMAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE, GAP} state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      rr_q, rr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [REQ_NUM-1:0] grant_q, grant_d;
  logic [REQ_NUM-1:0] done_q, done_d;
  logic [REQ_NUM-1:0] err_q, err_d;
  logic               send_en_q, send_en_d;
  logic [FW-1:0]      data_q, data_d;
  logic               arb_busy_q;

  logic               win_vld;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      cand;

  // First requesting index at or above the rr pointer, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      cand = PW'((32'(rr_q) + i) % REQ_NUM);
      if (!win_vld && req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
`ifdef TX_ARB_PRIO_EN
    if (req_i[0]) begin
      win_vld = 1'b1;
      win_idx = '0;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    done_d    = '0;
    err_d     = '0;
    send_en_d = send_en_q;
    data_d    = data_q;
    case (state_q)
      IDLE: begin
        if (win_vld && !tx_busy_i) begin
          state_d          = WAIT_START;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          send_en_d        = 1'b1;
          cnt_d            = '0;
          for (int unsigned i = 0; i < REQ_NUM; i++) begin
            if (PW'(i) == win_idx) data_d = req_data_i[i*FW +: FW];
          end
`ifdef TX_ARB_PRIO_EN
          if (!req_i[0])
            rr_d = (32'(win_idx) == REQ_NUM - 1) ? '0 : win_idx + 1'b1;
`else
          rr_d = (32'(win_idx) == REQ_NUM - 1) ? '0 : win_idx + 1'b1;
`endif
        end
      end
      WAIT_START: begin
        cnt_d = cnt_q + 1'b1;
        // cnt_q counts completed cycles, so send_en stays high START_TIMEOUT cycles.
        if (tx_busy_i) begin
          state_d   = WAIT_DONE;
          send_en_d = 1'b0;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          state_d   = GAP;
          err_d     = grant_q;
          grant_d   = '0;
          send_en_d = 1'b0;
          cnt_d     = '0;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy_i) begin
          state_d = GAP;
          done_d  = grant_q;
          grant_d = '0;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = IDLE;
        else                              cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= '0;
      send_en_q  <= 1'b0;
      data_q     <= '0;
      arb_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      send_en_q  <= send_en_d;
      data_q     <= data_d;
      arb_busy_q <= (state_d != IDLE);
    end
  end

  assign grant_o       = grant_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign send_en_o     = send_en_q;
  assign nbytes_data_o = data_q;
  assign arb_busy_o    = arb_busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: sender stub, event monitor and round-robin reference model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int BN  = 4;
  localparam int FW  = 8 * BN;
  localparam int ST  = 16;
  localparam int GAP = 2;
`ifdef TX_ARB_PRIO_EN
  localparam logic [N-1:0] PRIO_FIRST = 4'b0001;
`else
  localparam logic [N-1:0] PRIO_FIRST = 4'b0100;
`endif

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic [N-1:0]    req_i;
  logic [N*FW-1:0] req_data_i;
  logic [N-1:0]    grant_o, done_o, err_o;
  logic            send_en_o, tx_busy_i, arb_busy_o;
  logic [FW-1:0]   nbytes_data_o;

  logic [FW-1:0]   frame [N];
  logic            stub_busy, force_busy, stub_kill;
  logic [N-1:0]    never_mask;
  int              stub_delay, stub_len;

  int tests, fails, viol, model_ptr;
  logic [N-1:0]  gq [$];
  logic [FW-1:0] dq [$];
  logic [N:0]    oq [$];
  int            enq [$];
  int            exp_w [$];

  always #5 clk_i = ~clk_i;

  always_comb begin
    req_data_i = '0;
    for (int i = 0; i < N; i++) req_data_i[i*FW +: FW] = frame[i];
  end
  assign tx_busy_i = stub_busy | force_busy;

  uart_tx_arbiter #(.REQ_NUM(N), .BYTE_NUM(BN), .START_TIMEOUT(ST), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .req_data_i(req_data_i),
    .grant_o(grant_o), .done_o(done_o), .err_o(err_o), .send_en_o(send_en_o),
    .nbytes_data_o(nbytes_data_o), .tx_busy_i(tx_busy_i), .arb_busy_o(arb_busy_o)
  );

  // Sender stub: goes busy stub_delay cycles after a send_en rise, for stub_len cycles.
  initial begin : stub
    logic en_prev;
    int dly, lcnt;
    en_prev = 1'b0; dly = 0; lcnt = 0; stub_busy = 1'b0;
    forever begin
      @(negedge clk_i);
      if (stub_kill) begin
        stub_busy = 1'b0; dly = 0; lcnt = 0; en_prev = 1'b0;
      end else begin
        if (lcnt > 0) begin
          lcnt--;
          if (lcnt == 0) stub_busy = 1'b0;
        end
        if (dly > 0) begin
          dly--;
          if (dly == 0) begin stub_busy = 1'b1; lcnt = stub_len; end
        end
        if (send_en_o && !en_prev && ((grant_o & never_mask) == '0)) dly = stub_delay;
        en_prev = send_en_o;
      end
    end
  end

  // Records grants, outcomes and send_en high-run lengths; counts protocol violations.
  initial begin : monitor
    logic [N-1:0]  gprev;
    logic [FW-1:0] dprev;
    logic          eprev;
    int            hi, lo;
    gprev = '0; dprev = '0; eprev = 1'b0; hi = 0; lo = GAP;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        gprev = '0; dprev = '0; eprev = 1'b0; hi = 0; lo = GAP;
      end else begin
        if ((done_o != '0 && err_o != '0) || !$onehot0(done_o) || !$onehot0(err_o) || !$onehot0(grant_o)) viol++;
        if ((done_o | err_o) != '0 && (done_o | err_o) !== gprev) viol++;
        if (grant_o != '0 && !arb_busy_o) viol++;
        if (send_en_o && grant_o == '0) viol++;
        if (!(grant_o != '0 && gprev == '0) && nbytes_data_o !== dprev) viol++;
        if (grant_o != '0 && gprev == '0) begin gq.push_back(grant_o); dq.push_back(nbytes_data_o); end
        if (done_o != '0) oq.push_back({1'b0, done_o});
        if (err_o != '0)  oq.push_back({1'b1, err_o});
        if (send_en_o) begin
          if (!eprev && lo < GAP) viol++;
          hi++; lo = 0;
        end else begin
          if (eprev) enq.push_back(hi);
          hi = 0; lo++;
        end
        gprev = grant_o; dprev = nbytes_data_o; eprev = send_en_o;
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk_i); #1;
  endtask

  task automatic clear_mon();
    gq.delete(); dq.delete(); oq.delete(); enq.delete();
  endtask

  // Reference: winner is the pending index at the smallest forward distance from the pointer.
  function automatic int model_pick(input logic [N-1:0] pend);
    int w, best;
    w = -1; best = N;
`ifdef TX_ARB_PRIO_EN
    if (pend[0]) return 0;
`endif
    for (int j = 0; j < N; j++) begin
      if (pend[j] && ((j - model_ptr + N) % N) < best) begin
        best = (j - model_ptr + N) % N;
        w = j;
      end
    end
    if (w >= 0) model_ptr = (w + 1) % N;
    return w;
  endfunction

  task automatic run_set(input string name, input logic [N-1:0] mask, input logic [N-1:0] never,
                         input int dly, input int len);
    logic [N-1:0] pend, oh;
    int n, w, budget;
    exp_w.delete();
    pend = mask;
    n = $countones(mask);
    for (int k = 0; k < n; k++) begin
      w = model_pick(pend);
      exp_w.push_back(w);
      pend[w] = 1'b0;
    end
    clear_mon();
    never_mask = never; stub_delay = dly; stub_len = len;
    req_i = mask;
    budget = 0;
    while (oq.size() < n && budget < 300 * N) begin
      step(); budget++;
      foreach (oq[k]) req_i = req_i & ~oq[k][N-1:0];
    end
    req_i = '0;
    tests++;
    if (oq.size() < n) begin
      fails++;
      $display("FAIL %s_budget: got %0d outcomes, required %0d", name, oq.size(), n);
    end
    repeat (GAP + 4) step();
    tests++;
    if (gq.size() != n || oq.size() != n || enq.size() != n) begin
      fails++;
      $display("FAIL %s_counts: got grants=%0d outcomes=%0d enables=%0d, required %0d each",
               name, gq.size(), oq.size(), enq.size(), n);
    end else begin
      for (int k = 0; k < n; k++) begin
        oh = '0; oh[exp_w[k]] = 1'b1;
        tests++;
        if (gq[k] !== oh) begin fails++; $display("FAIL %s_grant%0d: got %b, required %b", name, k, gq[k], oh); end
        tests++;
        if (dq[k] !== frame[exp_w[k]]) begin
          fails++; $display("FAIL %s_data%0d: got %h, required %h", name, k, dq[k], frame[exp_w[k]]);
        end
        tests++;
        if (oq[k] !== {never[exp_w[k]], oh}) begin
          fails++; $display("FAIL %s_outcome%0d: got %b, required %b", name, k, oq[k], {never[exp_w[k]], oh});
        end
        tests++;
        if (enq[k] != (never[exp_w[k]] ? ST : dly + 1)) begin
          fails++; $display("FAIL %s_enlen%0d: got %0d, required %0d", name, k, enq[k], never[exp_w[k]] ? ST : dly + 1);
        end
      end
    end
    tests++;
    if (arb_busy_o !== 1'b0 || grant_o !== '0 || send_en_o !== 1'b0) begin
      fails++; $display("FAIL %s_idle: got busy=%b grant=%b en=%b, required 0", name, arb_busy_o, grant_o, send_en_o);
    end
  endtask

  task automatic test_reset();
    step();
    tests++;
    if ({grant_o, done_o, err_o, send_en_o, arb_busy_o} !== '0 || nbytes_data_o !== '0) begin
      fails++; $display("FAIL reset_hold: got grant=%b en=%b data=%h, required 0", grant_o, send_en_o, nbytes_data_o);
    end
    rst_n_i = 1'b1; stub_kill = 1'b0; model_ptr = 0;
    repeat (2) step();
    tests++;
    if ({grant_o, done_o, err_o, send_en_o, arb_busy_o} !== '0) begin
      fails++; $display("FAIL reset_idle: got grant=%b busy=%b, required 0", grant_o, arb_busy_o);
    end
  endtask

  task automatic test_all_four();
    for (int i = 0; i < N; i++) frame[i] = $urandom;
    run_set("all_four", 4'b1111, 4'b0000, 2, 6);
    tests++;
    if (gq.size() == 4 && {gq[0], gq[1], gq[2], gq[3]} !== 16'b0001_0010_0100_1000) begin
      fails++; $display("FAIL all_four_order: got %b %b %b %b, required 0001 0010 0100 1000", gq[0], gq[1], gq[2], gq[3]);
    end
  endtask

  task automatic test_single();
    int b, w;
    clear_mon();
    frame[2] = 32'hDEADBEEF; stub_delay = 3; stub_len = 200; never_mask = '0;
    w = model_pick(4'b0100);
    req_i = 4'b0100;
    step();
    tests++;
    if (grant_o !== 4'b0100 || send_en_o !== 1'b1 || w != 2) begin
      fails++; $display("FAIL single_grant: got grant=%b en=%b, required 0100 1", grant_o, send_en_o);
    end
    tests++;
    if (nbytes_data_o !== 32'hDEADBEEF) begin
      fails++; $display("FAIL single_data: got %h, required deadbeef", nbytes_data_o);
    end
    b = 0;
    while (!tx_busy_i && b < 50) begin step(); b++; end
    tests++;
    if (!tx_busy_i || send_en_o !== 1'b1) begin
      fails++; $display("FAIL single_busy_rise: got busy=%b en=%b, required 1 1", tx_busy_i, send_en_o);
    end
    step();
    tests++;
    if (send_en_o !== 1'b0 || grant_o !== 4'b0100 || arb_busy_o !== 1'b1) begin
      fails++; $display("FAIL single_en_fall: got en=%b grant=%b busy=%b, required 0 0100 1", send_en_o, grant_o, arb_busy_o);
    end
    b = 0;
    while (done_o == '0 && b < 400) begin step(); b++; end
    tests++;
    if (done_o !== 4'b0100 || err_o !== '0) begin
      fails++; $display("FAIL single_done: got done=%b err=%b, required 0100 0000", done_o, err_o);
    end
    req_i = '0;
    step();
    tests++;
    if (done_o !== '0 || grant_o !== '0) begin
      fails++; $display("FAIL single_pulse: got done=%b grant=%b, required 0", done_o, grant_o);
    end
    repeat (GAP + 2) step();
  endtask

  task automatic test_timeout();
    frame[0] = $urandom; frame[1] = $urandom;
    run_set("timeout", 4'b0011, 4'b0001, 4, 5);
    tests++;
    if (oq.size() == 2 && (oq[0] !== 5'b1_0001 || oq[1] !== 5'b0_0010)) begin
      fails++; $display("FAIL timeout_seq: got %b %b, required 10001 00010", oq[0], oq[1]);
    end
  endtask

  task automatic test_busy_idle();
    int bad, b, w;
    clear_mon();
    never_mask = '0; stub_delay = 2; stub_len = 5;
    force_busy = 1'b1;
    req_i = 4'b0001;
    bad = 0;
    repeat (6) begin step(); if (grant_o !== '0 || send_en_o !== 1'b0) bad++; end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL busy_hold: got %0d grant cycles, required 0", bad); end
    force_busy = 1'b0;
    w = model_pick(4'b0001);
    step();
    tests++;
    if (grant_o !== 4'b0001 || send_en_o !== 1'b1 || w != 0) begin
      fails++; $display("FAIL busy_release: got grant=%b en=%b, required 0001 1", grant_o, send_en_o);
    end
    b = 0;
    while (done_o == '0 && b < 100) begin step(); b++; end
    tests++;
    if (done_o !== 4'b0001) begin fails++; $display("FAIL busy_done: got %b, required 0001", done_o); end
    req_i = '0;
    repeat (GAP + 2) step();
  endtask

  task automatic test_reset_mid();
    int b, w;
    frame[1] = $urandom; frame[3] = $urandom;
    stub_delay = 3; stub_len = 200; never_mask = '0;
    w = model_pick(4'b0010);
    req_i = 4'b0010;
    b = 0;
    while (!tx_busy_i && b < 50) begin step(); b++; end
    repeat (3) step();
    tests++;
    if (arb_busy_o !== 1'b1 || grant_o !== 4'b0010 || send_en_o !== 1'b0 || w != 1) begin
      fails++; $display("FAIL rstmid_pre: got busy=%b grant=%b en=%b, required 1 0010 0", arb_busy_o, grant_o, send_en_o);
    end
    rst_n_i = 1'b0;
    #1;
    tests++;
    if (grant_o !== '0 || send_en_o !== 1'b0 || arb_busy_o !== 1'b0 || nbytes_data_o !== '0) begin
      fails++; $display("FAIL rstmid_async: got grant=%b en=%b busy=%b, required 0", grant_o, send_en_o, arb_busy_o);
    end
    stub_kill = 1'b1; req_i = '0;
    repeat (2) step();
    rst_n_i = 1'b1; stub_kill = 1'b0; model_ptr = 0;
    step();
    run_set("rstmid_fresh", 4'b1010, 4'b0000, 3, 4);
    tests++;
    if (gq.size() > 0 && gq[0] !== 4'b0010) begin
      fails++; $display("FAIL rstmid_ptr: got first grant %b, required 0010", gq[0]);
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < N; i++) frame[i] = $urandom;
    run_set("prio_setup", 4'b0010, 4'b0000, 2, 3);
    run_set("prio", 4'b0101, 4'b0000, 2, 3);
    tests++;
    if (gq.size() > 0 && gq[0] !== PRIO_FIRST) begin
      fails++; $display("FAIL prio_first: got %b, required %b", gq[0], PRIO_FIRST);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] mask, never;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < N; i++) frame[i] = $urandom;
      mask  = N'($urandom_range(1, (1 << N) - 1));
      never = mask & N'($urandom) & N'($urandom);
      run_set("random", mask, never, $urandom_range(1, 10), $urandom_range(1, 20));
    end
  endtask

  initial begin
    tests = 0; fails = 0; viol = 0; model_ptr = 0;
    rst_n_i = 1'b0; req_i = '0; force_busy = 1'b0; stub_kill = 1'b1;
    never_mask = '0; stub_delay = 3; stub_len = 5;
    for (int i = 0; i < N; i++) frame[i] = '0;
    repeat (2) step();
    test_reset();
    test_all_four();
    test_single();
    test_timeout();
    test_busy_idle();
    test_reset_mid();
    test_priority();
    test_random();
    tests++;
    if (viol != 0) begin fails++; $display("FAIL protocol: got %0d violations, required 0", viol); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one n-byte UART sender between REQ_NUM requesters using round-robin arbitration.
- The sender is the multi-byte frame transmitter with a rising-edge `send_en` input and a `busy` output.
- Latches the winning requester's frame, pulses the sender's enable, and tracks sender busy to detect completion.
- Returns a per-requester done or error pulse.
- Sits between application-side producers (status, ADC, debug) and the single UART TX pin.

Parameters:
- REQ_NUM, 4, number of requesters (2..8).
- BYTE_NUM, 4, bytes per frame; must match the sender's BYTE_NUM.
- START_TIMEOUT, 16, max cycles to wait for tx_busy_i rise after send_en_o asserts (>=4).
- GAP_CYCLES, 2, idle cycles with send_en_o low between frames (>=1), so the sender's edge detector re-arms.

Ports:
- clk_i  input  1  system clock
- rst_n_i  input  1  asynchronous active-low reset
- req_i  input  REQ_NUM  per-requester request level; held until own done_o/err_o
- req_data_i  input  REQ_NUM*8*BYTE_NUM  frame per requester; slice i = [i*8*BYTE_NUM +: 8*BYTE_NUM]; MSB byte sent first
- grant_o  output  REQ_NUM  one-hot owner of the sender; zero when idle
- done_o  output  REQ_NUM  one-cycle pulse, frame completed
- err_o  output  REQ_NUM  one-cycle pulse, sender never went busy (timeout)
- send_en_o  output  1  enable to sender; sender acts on its rising edge
- nbytes_data_o  output  8*BYTE_NUM  latched frame to sender
- tx_busy_i  input  1  sender busy flag
- arb_busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, rr pointer=0, grant_o=0, done_o=0, err_o=0, send_en_o=0, nbytes_data_o=0, arb_busy_o=0, timeout counter=0.
- All outputs are registered.
- FSM states: IDLE, WAIT_START, WAIT_DONE, GAP.
- IDLE:
  - At a clock edge where any req_i bit is high and tx_busy_i=0, the arbiter selects a winner.
  - The winner is the first set bit searching from the rr pointer upward, wrapping modulo REQ_NUM.
  - Next cycle: grant_o[w]=1, nbytes_data_o = slice w, send_en_o=1, counter=0, state=WAIT_START.
  - Latency from request to send_en_o is one cycle.
  - The rr pointer becomes (w+1) mod REQ_NUM.
- IDLE with tx_busy_i=1 (foreign or leftover activity): no grant until tx_busy_i=0.
- WAIT_START:
  - send_en_o stays 1 and the counter increments each cycle.
  - tx_busy_i=1 sampled: state=WAIT_DONE, send_en_o=0 on the next cycle.
  - Counter reaches START_TIMEOUT with tx_busy_i still 0: err_o[w] pulses for one cycle, send_en_o=0, grant_o=0, state=GAP.
- WAIT_DONE:
  - send_en_o=0.
  - tx_busy_i=0 sampled: done_o[w] pulses for one cycle, grant_o=0, state=GAP.
  - No timeout applies in this state.
- GAP: hold for GAP_CYCLES cycles with send_en_o=0, then state=IDLE.
- nbytes_data_o is stable from grant until the next grant; it is never altered mid-frame.
- Requester drops req_i mid-frame: ignored; the frame completes and done_o still pulses.
- A requester still high after its done is a new request; round-robin serves other pending requesters first.
- Simultaneous requests from all requesters are served in pointer order, each getting exactly one frame per round.
- done_o and err_o are never both set, and at most one bit of each is set.
- Reset mid-frame: outputs clear immediately; the sender sees send_en_o fall.

Optional Feature:
- Macro: TX_ARB_PRIO_EN.
- Defined:
  - Requester 0 is urgent; in IDLE, req_i[0]=1 wins regardless of the rr pointer.
  - The pointer is not updated on such an override win.
  - All other arbitration is unchanged.
- Undefined: pure round-robin as above; no extra logic.

Test Plan:
1. Single request: req_i=4'b0100 with frame 32'hDEADBEEF; stub raises busy 3 cycles after send_en_o and drops it after 200 cycles -> grant_o=4'b0100 one cycle after the request, nbytes_data_o=32'hDEADBEEF, send_en_o falls the cycle after busy is seen, then done_o=4'b0100 for one cycle.
2. All four requesters assert together, pointer=0 -> grants in order 0,1,2,3; each grant is separated by >= GAP_CYCLES with send_en_o=0; four done pulses.
3. Stub never raises busy -> after 16 cycles of send_en_o=1, err_o pulses for the owner, then GAP, then the next requester is granted.
4. tx_busy_i=1 while in IDLE and req_i=4'b0001 -> no grant until tx_busy_i=0; grant follows one cycle later.
5. Assert rst_n_i=0 during WAIT_DONE -> grant_o, send_en_o and arb_busy_o go to 0 without a clock edge; after release, the pointer is 0 and a fresh request is granted normally.
6. With TX_ARB_PRIO_EN defined: pointer=2, req_i=4'b0101 -> requester 0 is granted first, then requester 2. Without the macro, requester 2 is granted first.
